// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with one registered output slot
// Combinational decode of instr feeds a valid/ready slot with flush and sticky halt.
module decode_stage #(
  parameter int OPERAND_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] instr,
  input  logic [OPERAND_WIDTH-1:0] pc_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               alu_opcode,
  output logic [1:0]               alu_funct,
  output logic [2:0]               rs,
  output logic [2:0]               rt,
  output logic [2:0]               rd,
  output logic [OPERAND_WIDTH-1:0] imm,
  output logic [OPERAND_WIDTH-1:0] pc_out,
  output logic                     reg_write,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     is_branch,
  output logic                     is_jump,
  output logic                     exc,
  output logic                     halted,
  output logic [15:0]              dec_count
);

  localparam int W = OPERAND_WIDTH;

  logic [4:0]   op;
  logic [2:0]   d_rd;
  logic [W-1:0] d_imm;
  logic         d_reg_write;
  logic         d_mem_read;
  logic         d_mem_write;
  logic         d_is_branch;
  logic         d_is_jump;
  logic         d_exc;
  logic         accept;

  assign op       = instr[15:11];
  assign in_ready = ~halted & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    d_rd = 3'd0;
    casez (op)
      5'b11001, 5'b11010, 5'b11011, 5'b111??: d_rd = instr[4:2];
      5'b010??, 5'b101??, 5'b10001:           d_rd = instr[7:5];
      5'b11000, 5'b10010, 5'b10011:           d_rd = instr[10:8];
      5'b0011?:                               d_rd = 3'd7;
      default:                                d_rd = 3'd0;
    endcase
  end

  always_comb begin
    d_imm = '0;
    casez (op)
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
        d_imm = {{(W-5){instr[4]}}, instr[4:0]};
      5'b01010, 5'b01011, 5'b101??:
        d_imm = {{(W-5){1'b0}}, instr[4:0]};
      5'b011??, 5'b11000, 5'b00101, 5'b00111:
        d_imm = {{(W-8){instr[7]}}, instr[7:0]};
      5'b10010:
        d_imm = {{(W-8){1'b0}}, instr[7:0]};
      5'b00100, 5'b00110:
        d_imm = {{(W-11){instr[10]}}, instr[10:0]};
      default:
        d_imm = '0;
    endcase
  end

  always_comb begin
    d_reg_write = 1'b0;
    casez (op)
      5'b010??, 5'b101??, 5'b1101?, 5'b11001, 5'b111??,
      5'b10001, 5'b10011, 5'b11000, 5'b10010, 5'b0011?:
        d_reg_write = 1'b1;
      default:
        d_reg_write = 1'b0;
    endcase
    d_mem_read  = (op == 5'b10001);
    d_mem_write = (op == 5'b10000) | (op == 5'b10011);
    d_is_branch = (op[4:2] == 3'b011);
    d_is_jump   = (op[4:2] == 3'b001);
    d_exc       = (op == 5'b00010) | (op == 5'b00011);
  end

  // Flush wins over a same-cycle accept: the incoming word is dropped and not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_opcode <= 5'd0;
      alu_funct  <= 2'd0;
      rs         <= 3'd0;
      rt         <= 3'd0;
      rd         <= 3'd0;
      imm        <= '0;
      pc_out     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      is_branch  <= 1'b0;
      is_jump    <= 1'b0;
      exc        <= 1'b0;
      halted     <= 1'b0;
      dec_count  <= 16'd0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      alu_opcode <= 5'd0;
      alu_funct  <= 2'd0;
      rs         <= 3'd0;
      rt         <= 3'd0;
      rd         <= 3'd0;
      imm        <= '0;
      pc_out     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      is_branch  <= 1'b0;
      is_jump    <= 1'b0;
      exc        <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_opcode <= op;
      alu_funct  <= instr[1:0];
      rs         <= instr[10:8];
      rt         <= instr[7:5];
      rd         <= d_rd;
      imm        <= d_imm;
      pc_out     <= pc_in;
      reg_write  <= d_reg_write;
      mem_read   <= d_mem_read;
      mem_write  <= d_mem_write;
      is_branch  <= d_is_branch;
      is_jump    <= d_is_jump;
      exc        <= d_exc;
      dec_count  <= dec_count + 16'd1;
      if (op == 5'b00000) begin
        halted <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction-decode stage between fetch and the ALU/execute stage of the 16-bit core. It accepts one 16-bit instruction per handshake and decodes it into the opcode/funct pair the ALU consumes, register specifiers, an extended immediate and control strobes. Results are held in a single registered output slot with valid/ready flow control, flush and halt handling.

## Interface
- `OPERAND_WIDTH`, default 16: instruction, immediate and PC width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  the stage can accept an instruction this cycle.
- `instr`  in  16  instruction word.
- `pc_in`  in  16  PC+2 of `instr`.
- `flush`  in  1  squashes the held slot (taken branch or jump in execute).
- `out_valid`  out  1  the decoded slot is valid.
- `out_ready`  in  1  execute consumes the slot.
- `alu_opcode`  out  5  `instr[15:11]`.
- `alu_funct`  out  2  `instr[1:0]`.
- `rs`, `rt`, `rd`  out  3 each  source, second source and destination registers.
- `imm`  out  16  extended immediate.
- `pc_out`  out  16  registered `pc_in`.
- `reg_write`, `mem_read`, `mem_write`, `is_branch`, `is_jump`  out  1 each  control strobes.
- `exc`  out  1  SIIC or RTI decoded.
- `halted`  out  1  sticky; HALT has been accepted.
- `dec_count`  out  16  count of accepted instructions.

## Operation
- **Handshake.** Accept when `in_valid & in_ready`. `in_ready = ~halted & (~out_valid | out_ready)`.
- **Slot update.** On accept, all decoded fields load into the slot and `out_valid` goes to 1. If the slot is consumed with no accept, `out_valid` goes to 0.
- **Field extraction.**
  - `rs = instr[10:8]`.
  - `rt = instr[7:5]`.
  - `rd` by format:
    - R-format (opcodes 11001, 11010, 11011, 111xx): `instr[4:2]`.
    - I1-format (010xx, 101xx, 10001): `instr[7:5]`.
    - LBI (11000), SLBI (10010), STU (10011): `instr[10:8]`.
    - JAL (00110), JALR (00111): 7.
    - All others: 0.
- **Immediate extension.**
  - Sign-extended `instr[4:0]`: 01000, 01001, 10000, 10001, 10011.
  - Zero-extended `instr[4:0]`: 01010, 01011, 101xx.
  - Sign-extended `instr[7:0]`: 011xx, 11000, 00101, 00111.
  - Zero-extended `instr[7:0]`: 10010.
  - Sign-extended `instr[10:0]`: 00100, 00110.
  - All others: 0.
- **Control strobes.**
  - `reg_write` = 1 for:
    - register ALU/shift ops (010xx, 101xx, 1101x, 11001, 111xx);
    - LD, STU, LBI, SLBI, JAL, JALR.
  - `mem_read` = LD.
  - `mem_write` = ST or STU.
  - `is_branch` = 011xx.
  - `is_jump` = 001xx.
  - `exc` = 00010 or 00011.
- **HALT (00000).** Accepted normally and presented downstream with all strobes 0. `halted` sets on the accept edge and holds until reset. NOP (00001) also has all strobes 0 but does not halt.
- **Flush.**
  - `flush` clears `out_valid` at the next edge and overrides the slot contents.
  - An instruction accepted in the same cycle as `flush` is discarded: `out_valid` = 0 and `dec_count` is not incremented.
  - `flush` does not clear `halted`.
- **Counter.** `dec_count` increments by 1 per non-flushed accept and wraps 0xFFFF → 0x0000.

## Timing
- Latency: 1 cycle from the accept edge to `out_valid`/fields.
- Throughput: 1 instruction/cycle when `out_ready` = 1.
- Decode is combinational on `instr`; every output is registered. No output depends combinationally on `instr`, `in_valid` or `flush`.
- `in_ready` is combinational on `out_valid`, `out_ready` and `halted`.
- Stall: while `out_valid & ~out_ready`, all slot fields hold stable and `in_ready` = 0.
- Reset (asynchronous, `rst_n` = 0):
  - `out_valid`, `halted`, `dec_count` and all fields/strobes go to 0.
  - Mid-stall reset drops the held instruction.
  - Outputs remain 0 until the first accept after `rst_n` rises.
- Simultaneous consume and accept: the slot is replaced in the same edge and `out_valid` stays 1.

## Test plan
- ADDI R1,R2,-1, `instr` = 0x423F accepted with `out_ready` = 1 -> next cycle:
  - `out_valid` = 1, `alu_opcode` = 01000, `rs` = 2, `rd` = 1;
  - `imm` = 0xFFFF, `reg_write` = 1, `dec_count` = 1.
- XORI 0x523F -> `imm` = 0x001F, `rd` = 1. ADD 0xD94C -> `rs` = 1, `rt` = 2, `rd` = 3, `alu_funct` = 00, `reg_write` = 1.
- JAL 0x37FE -> `imm` = 0xFFFE, `rd` = 7, `is_jump` = 1, `reg_write` = 1.
- Backpressure, in this order:
  - Hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 -> `in_ready` = 0 and the slot stays stable.
  - Raise `out_ready` -> a new instruction loads on the same edge and `out_valid` stays 1.
- Flush with a concurrent accept -> next cycle `out_valid` = 0 and `dec_count` is unchanged.
- HALT 0x0000 accepted -> `halted` = 1 and `in_ready` = 0 permanently.
  - Assert `rst_n` = 0 asynchronously mid-cycle -> all outputs 0 immediately.
  - After `rst_n` rises, `in_ready` = 1.
